vscale_dom_share_gen: RTL and testbench

VSCALE_DOM_SHARE_GEN -- requirements
Module: vscale_dom_share_gen

---
 rtl/vscale_dom_share_gen_pkg.sv | 19 +
 rtl/vscale_dom_share_gen_if.sv | 26 ++
 rtl/vscale_dom_share_gen_lfsr.sv | 34 +++
 rtl/vscale_dom_share_gen.sv | 94 +++++++++
 tb/tb_vscale_dom_share_gen.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/vscale_dom_share_gen_pkg.sv
// Shared constants and types for the Boolean share generator:
// FSM encodings and the Galois LFSR parameters plus its step function.
package vscale_dom_share_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GEN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam int          LFSR_W       = 32;
    localparam logic [31:0] LFSR_POLY    = 32'h8020_0003;  // x^32+x^22+x^2+x+1
    localparam logic [31:0] LFSR_RST_VAL = 32'hACE1_0001;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        lfsr_step = (s >> 1) ^ (s[0] ? LFSR_POLY : '0);
    endfunction

endpackage

// File: rtl/vscale_dom_share_gen_if.sv
// Handshake bundle between a word producer/consumer (master) and the
// share generator (slave).
interface vscale_dom_share_gen_if #(
    parameter int DWIDTH = 32,
    parameter int SHARES = 2
);
    logic                     InValidxSI;
    logic                     InReadyxSO;
    logic [DWIDTH-1:0]        InDataxDI;
    logic                     SeedValidxSI;
    logic [31:0]              SeedxDI;
    logic                     OutValidxSO;
    logic                     OutReadyxSI;
    logic [SHARES*DWIDTH-1:0] OutSharesxDO;
    logic                     BusyxSO;

    modport master (
        output InValidxSI, InDataxDI, SeedValidxSI, SeedxDI, OutReadyxSI,
        input  InReadyxSO, OutValidxSO, OutSharesxDO, BusyxSO
    );

    modport slave (
        input  InValidxSI, InDataxDI, SeedValidxSI, SeedxDI, OutReadyxSI,
        output InReadyxSO, OutValidxSO, OutSharesxDO, BusyxSO
    );
endinterface

// File: rtl/vscale_dom_share_gen_lfsr.sv
// 32-bit Galois LFSR mask source; a load replaces the state (zero seed is
// forced to 1 so the register can never lock up), a step advances it once.
module vscale_dom_lfsr
    import vscale_dom_share_gen_pkg::*;
(
    input  logic              ClkxCI,
    input  logic              RstxRBI,
    input  logic              StepxSI,
    input  logic              LoadxSI,
    input  logic [LFSR_W-1:0] SeedxDI,
    output logic [LFSR_W-1:0] StatexDO
);
    logic [LFSR_W-1:0] state_q;
    logic [LFSR_W-1:0] state_d;

    always_comb begin
        state_d = state_q;
        if (LoadxSI) begin
            state_d = (SeedxDI == '0) ? LFSR_W'(1) : SeedxDI;
        end else if (StepxSI) begin
            state_d = lfsr_step(state_q);
        end
    end

    always_ff @(posedge ClkxCI or negedge RstxRBI) begin
        if (!RstxRBI) begin
            state_q <= LFSR_RST_VAL;
        end else begin
            state_q <= state_d;
        end
    end

    assign StatexDO = state_q;
endmodule

// File: rtl/vscale_dom_share_gen.sv
// Splits one unmasked word into SHARES Boolean shares (XOR of all lanes
// equals the input) using fresh LFSR masks, one mask per GEN cycle.
module vscale_dom_share_gen
    import vscale_dom_share_gen_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int SHARES = 2
) (
    input  logic                   ClkxCI,
    input  logic                   RstxRBI,
    vscale_dom_share_gen_if.slave  bus
);
    localparam int CW = $clog2(SHARES) + 1;

    state_e                   state_q;
    logic [CW-1:0]            cnt_q;
    logic [SHARES*DWIDTH-1:0] shares_q;
    logic [SHARES*DWIDTH-1:0] gen_shares_d;
    logic                     out_valid_q;
    logic                     busy_q;
    logic [LFSR_W-1:0]        lfsr_state;
    logic [DWIDTH-1:0]        mask;
    logic                     in_ready;
    logic                     seed_load;

    assign in_ready  = (state_q == ST_IDLE) && !bus.SeedValidxSI;
    assign seed_load = (state_q == ST_IDLE) && bus.SeedValidxSI;
    assign mask      = lfsr_state[DWIDTH-1:0];

    vscale_dom_lfsr u_lfsr (
        .ClkxCI   (ClkxCI),
        .RstxRBI  (RstxRBI),
        .StepxSI  (state_q == ST_GEN),
        .LoadxSI  (seed_load),
        .SeedxDI  (bus.SeedxDI),
        .StatexDO (lfsr_state)
    );

    // Lane 0 absorbs every mask; lane cnt_q receives the current mask.
    for (genvar gi = 0; gi < SHARES; gi++) begin : g_lane
        if (gi == 0) begin : g_l0
            assign gen_shares_d[0 +: DWIDTH] = shares_q[0 +: DWIDTH] ^ mask;
        end else begin : g_ln
            assign gen_shares_d[gi*DWIDTH +: DWIDTH] =
                (cnt_q == CW'(gi)) ? mask : shares_q[gi*DWIDTH +: DWIDTH];
        end
    end

    always_ff @(posedge ClkxCI or negedge RstxRBI) begin
        if (!RstxRBI) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shares_q    <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.InValidxSI && in_ready) begin
                        shares_q <= {{((SHARES-1)*DWIDTH){1'b0}}, bus.InDataxDI};
                        cnt_q    <= CW'(1);
                        state_q  <= ST_GEN;
                        busy_q   <= 1'b1;
                    end
                end
                ST_GEN: begin
                    shares_q <= gen_shares_d;
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == CW'(SHARES-1)) begin
                        state_q     <= ST_HOLD;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (bus.OutReadyxSI) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.InReadyxSO   = in_ready;
    assign bus.OutValidxSO  = out_valid_q;
    assign bus.BusyxSO      = busy_q;
    assign bus.OutSharesxDO = shares_q;
endmodule

// File: tb/tb_vscale_dom_share_gen.sv
// Directed bench for the share generator: a 2-share and a 3-share instance
// share clock and reset; expected shares come from hand values and a local LFSR model.
module tb_vscale_dom_share_gen;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   vec_cnt = 0;
    int   err_cnt = 0;
    logic [31:0] m3;

    vscale_dom_share_gen_if #(.DWIDTH(32), .SHARES(2)) if2 ();
    vscale_dom_share_gen_if #(.DWIDTH(32), .SHARES(3)) if3 ();

    vscale_dom_share_gen #(.DWIDTH(32), .SHARES(2)) dut2 (
        .ClkxCI (clk), .RstxRBI (rst_n), .bus (if2.slave)
    );
    vscale_dom_share_gen #(.DWIDTH(32), .SHARES(3)) dut3 (
        .ClkxCI (clk), .RstxRBI (rst_n), .bus (if3.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_step(input logic [31:0] s);
        logic [31:0] n;
        n = {1'b0, s[31:1]};
        if (s[0]) n = n ^ 32'h8020_0003;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic hs2(input string tag);
        if2.OutReadyxSI = 1'b1;
        tick();
        if2.OutReadyxSI = 1'b0;
        chk({tag, "_vdrop"}, 96'(if2.OutValidxSO), 96'(0));
        chk({tag, "_idle"},  96'(if2.BusyxSO),     96'(0));
        $display("xfer dut2 %s done", tag);
    endtask

    // Accept a word on dut2 and advance to HOLD (one GEN cycle).
    task automatic word2(input logic [31:0] w);
        if2.InValidxSI = 1'b1;
        if2.InDataxDI  = w;
        tick();
        if2.InValidxSI = 1'b0;
        tick();
    endtask

    task automatic run3(input logic [31:0] w, input int stall, input string tag);
        logic [31:0] r1, r2;
        logic [95:0] exp;
        r1 = m3;
        m3 = model_step(m3);
        r2 = m3;
        m3 = model_step(m3);
        exp = {r2, r1, w ^ r1 ^ r2};
        if3.InValidxSI = 1'b1;
        if3.InDataxDI  = w;
        tick();
        if3.InDataxDI  = ~w;  // ignored while busy
        chk({tag, "_rdy_gen"}, 96'(if3.InReadyxSO), 96'(0));
        tick();
        chk({tag, "_v_gen"},   96'(if3.OutValidxSO), 96'(0));
        tick();
        chk({tag, "_v_hold"},  96'(if3.OutValidxSO), 96'(1));
        chk({tag, "_shares"},  if3.OutSharesxDO, exp);
        chk({tag, "_xor"}, 96'(if3.OutSharesxDO[31:0] ^ if3.OutSharesxDO[63:32] ^ if3.OutSharesxDO[95:64]), 96'(w));
        for (int s = 0; s < stall; s++) begin
            tick();
            chk({tag, "_stall"}, {if3.OutSharesxDO[94:0] ^ exp[94:0], if3.OutValidxSO & ~if3.InReadyxSO},
                {95'(0), 1'b1} | {if3.OutSharesxDO[95] ^ exp[95], 95'(0)});
        end
        if3.OutReadyxSI = 1'b1;
        tick();
        if3.OutReadyxSI = 1'b0;
        if3.InValidxSI  = 1'b0;
        chk({tag, "_noreacc"}, 96'({if3.BusyxSO, if3.OutValidxSO}), 96'(0));
        $display("xfer dut3 %s word=%h stall=%0d shares=%h", tag, w, stall, exp);
    endtask

    initial begin
        if2.InValidxSI = 0; if2.InDataxDI = '0; if2.SeedValidxSI = 0; if2.SeedxDI = '0; if2.OutReadyxSI = 0;
        if3.InValidxSI = 0; if3.InDataxDI = '0; if3.SeedValidxSI = 0; if3.SeedxDI = '0; if3.OutReadyxSI = 0;
        #2;
        chk("rst_rdy",    96'(if2.InReadyxSO),  96'(1));
        chk("rst_valid",  96'(if2.OutValidxSO), 96'(0));
        chk("rst_busy",   96'(if2.BusyxSO),     96'(0));
        chk("rst_shares", 96'(if2.OutSharesxDO), 96'(0));
        chk("rst_shares3", if3.OutSharesxDO,     96'(0));
        $display("reset state checked");
        tick();
        rst_n = 1'b1;

        // Basic word from reset seed
        if2.InValidxSI = 1'b1;
        if2.InDataxDI  = 32'h1234_5678;
        tick();
        if2.InValidxSI = 1'b0;
        chk("b_gen_valid", 96'(if2.OutValidxSO), 96'(0));
        chk("b_gen_busy",  96'(if2.BusyxSO),     96'(1));
        chk("b_gen_rdy",   96'(if2.InReadyxSO),  96'(0));
        tick();
        chk("b_valid",  96'(if2.OutValidxSO), 96'(1));
        chk("b_shares", 96'(if2.OutSharesxDO), 96'({32'hACE1_0001, 32'hBED5_5679}));
        tick(); tick();
        chk("b_stall", 96'({if2.OutValidxSO, if2.OutSharesxDO}), 96'({1'b1, 32'hACE1_0001, 32'hBED5_5679}));
        hs2("basic");

        // Zero seed becomes 1
        if2.SeedValidxSI = 1'b1;
        if2.SeedxDI      = 32'h0;
        #1;
        chk("z_rdy", 96'(if2.InReadyxSO), 96'(0));
        tick();
        if2.SeedValidxSI = 1'b0;
        word2(32'hFFFF_FFFF);
        chk("z_shares", 96'(if2.OutSharesxDO), 96'({32'h0000_0001, 32'hFFFF_FFFE}));
        hs2("zseed");

        // Seed and input together: seed wins, word taken next cycle
        if2.SeedValidxSI = 1'b1;
        if2.SeedxDI      = 32'h0000_0010;
        if2.InValidxSI   = 1'b1;
        if2.InDataxDI    = 32'hA5A5_A5A5;
        #1;
        chk("p_rdy", 96'(if2.InReadyxSO), 96'(0));
        tick();
        if2.SeedValidxSI = 1'b0;
        chk("p_noacc", 96'(if2.BusyxSO), 96'(0));
        tick();
        if2.InValidxSI = 1'b0;
        chk("p_acc", 96'(if2.BusyxSO), 96'(1));
        tick();
        chk("p_shares", 96'(if2.OutSharesxDO), 96'({32'h0000_0010, 32'hA5A5_A5B5}));
        hs2("prio");

        // Seed pulse in HOLD is ignored
        word2(32'h0F0F_0F0F);
        chk("h_shares", 96'(if2.OutSharesxDO), 96'({32'h0000_0008, 32'h0F0F_0F07}));
        if2.SeedValidxSI = 1'b1;
        if2.SeedxDI      = 32'hDEAD_BEEF;
        tick();
        if2.SeedValidxSI = 1'b0;
        chk("h_keep", 96'({if2.OutValidxSO, if2.OutSharesxDO}), 96'({1'b1, 32'h0000_0008, 32'h0F0F_0F07}));
        hs2("holdseed");
        word2(32'h0000_0000);
        chk("h_next", 96'(if2.OutSharesxDO), 96'({32'h0000_0004, 32'h0000_0004}));
        hs2("noreseed");

        // Reset mid-HOLD (dut2)
        word2(32'h3333_3333);
        chk("rh_valid", 96'(if2.OutValidxSO), 96'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rh_vdrop", 96'(if2.OutValidxSO), 96'(0));
        chk("rh_clear", 96'(if2.OutSharesxDO), 96'(0));
        #1;
        rst_n = 1'b1;
        tick();
        chk("rh_nopart", 96'({if2.BusyxSO, if2.OutValidxSO}), 96'(0));
        word2(32'h1234_5678);
        chk("rh_lfsr", 96'(if2.OutSharesxDO), 96'({32'hACE1_0001, 32'hBED5_5679}));
        hs2("afterrst");

        // Reset mid-GEN (dut3)
        if3.InValidxSI = 1'b1;
        if3.InDataxDI  = 32'h5555_5555;
        tick();
        if3.InValidxSI = 1'b0;
        chk("rg_busy", 96'(if3.BusyxSO), 96'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rg_abort", 96'({if3.BusyxSO, if3.OutValidxSO}), 96'(0));
        #1;
        rst_n = 1'b1;
        tick(); tick(); tick();
        chk("rg_nopart", 96'({if3.BusyxSO, if3.OutValidxSO}), 96'(0));

        // 3-share word from reset seed, hand values
        if3.InValidxSI = 1'b1;
        if3.InDataxDI  = 32'h1234_5678;
        tick();
        if3.InValidxSI = 1'b0;
        tick(); tick();
        chk("s3_shares", if3.OutSharesxDO, {32'hD650_8003, 32'hACE1_0001, 32'h6885_D67A});
        if3.OutReadyxSI = 1'b1;
        tick();
        if3.OutReadyxSI = 1'b0;
        $display("xfer dut3 hand word done");

        m3 = model_step(model_step(32'hACE1_0001));
        for (int i = 0; i < 30; i++) begin
            run3($urandom, int'($urandom_range(0, 3)), $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
